// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - glyph constants, mode encoding and segment decoder for the BCD counter display
package bcd_disp_pkg;

    typedef enum logic {
        MODE_PAUSE = 1'b0,
        MODE_RUN   = 1'b1
    } mode_t;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0        = 7'b100_0000;
    localparam logic [6:0] SEG_1        = 7'b111_1001;
    localparam logic [6:0] SEG_2        = 7'b010_0100;
    localparam logic [6:0] SEG_3        = 7'b011_0000;
    localparam logic [6:0] SEG_4        = 7'b001_1001;
    localparam logic [6:0] SEG_5        = 7'b001_0010;
    localparam logic [6:0] SEG_6        = 7'b000_0010;
    localparam logic [6:0] SEG_7        = 7'b111_1000;
    localparam logic [6:0] SEG_8        = 7'b000_0000;
    localparam logic [6:0] SEG_9        = 7'b001_0000;
    localparam logic [6:0] SEG_ARROW_UP = 7'b101_1100;
    localparam logic [6:0] SEG_ARROW_DN = 7'b110_0011;
    localparam logic [6:0] SEG_BLANK    = 7'h7F;

    // Display value codes: 0-9 are digits, two codes select the arrows, anything else blanks
    localparam logic [4:0] VAL_ARROW_UP = 5'h10;
    localparam logic [4:0] VAL_ARROW_DN = 5'h11;
    localparam logic [4:0] VAL_BLANK    = 5'h1F;

    function automatic logic [6:0] seg_decode(input logic [4:0] v);
        logic [6:0] s;
        s = SEG_BLANK;
        case (v)
            5'd0:         s = SEG_0;
            5'd1:         s = SEG_1;
            5'd2:         s = SEG_2;
            5'd3:         s = SEG_3;
            5'd4:         s = SEG_4;
            5'd5:         s = SEG_5;
            5'd6:         s = SEG_6;
            5'd7:         s = SEG_7;
            5'd8:         s = SEG_8;
            5'd9:         s = SEG_9;
            VAL_ARROW_UP: s = SEG_ARROW_UP;
            VAL_ARROW_DN: s = SEG_ARROW_DN;
            default:      s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounce a raw pad input and emit a one-cycle pulse on its debounced rising edge
module btn_conditioner #(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);
    localparam int            RW       = $clog2(DEB_LEN + 1);
    localparam logic [RW-1:0] RUN_FULL = RW'(DEB_LEN - 1);

    logic [RW-1:0] run_len;
    logic          armed;
    logic          stable;

    // The current sample completes a full run of DEB_LEN ones
    assign stable = raw && (run_len == RUN_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_len <= '0;
            level   <= 1'b0;
            pulse   <= 1'b0;
            armed   <= 1'b0;
        end else begin
            if (!raw) begin
                run_len <= '0;
            end else if (run_len != RUN_FULL) begin
                run_len <= run_len + 1'b1;
            end
            level <= stable;
            // A button held through reset stays disarmed until it is seen released
            pulse <= stable && !level && armed;
            armed <= armed || !raw;
        end
    end

endmodule

// File: rtl/bcd_updown_counter_disp.sv
// rtl/bcd_updown_counter_disp.sv - N-digit BCD up/down counter with conditioned buttons and multiplexed 7-seg
module bcd_updown_counter_disp
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int NUM_SPEEDS = 3,
    parameter int SLOW_EXP   = 25,
    parameter int SCAN_EXP   = 10,
    parameter int DEB_LEN    = 4,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  speed_up,
    input  logic                  speed_down,
    output logic [NUM_DIGITS+1:0] DIGIT,
    output logic [6:0]            DISPLAY,
    output logic                  max,
    output logic                  min
);
    localparam int             SPW       = (NUM_SPEEDS > 2) ? $clog2(NUM_SPEEDS) : 1;
    localparam int             NPOS      = NUM_DIGITS + 2;
    localparam int             PW        = $clog2(NPOS);
    localparam int             CW        = 4 * NUM_DIGITS;
    localparam logic [SPW-1:0] SPEED_MAX = SPW'(NUM_SPEEDS - 1);
    localparam logic [PW-1:0]  POS_LAST  = PW'(NPOS - 1);
    localparam bit             WRAP_EN   = (WRAP != 0);

    logic en_pulse, up_pulse, down_pulse, dir_db;
    logic en_level_unused, up_level_unused, down_level_unused, dir_pulse_unused;

    btn_conditioner #(.DEB_LEN(DEB_LEN)) u_btn_en (
        .clk(clk), .rst(rst), .raw(en), .level(en_level_unused), .pulse(en_pulse)
    );
    btn_conditioner #(.DEB_LEN(DEB_LEN)) u_btn_dir (
        .clk(clk), .rst(rst), .raw(dir), .level(dir_db), .pulse(dir_pulse_unused)
    );
    btn_conditioner #(.DEB_LEN(DEB_LEN)) u_btn_up (
        .clk(clk), .rst(rst), .raw(speed_up), .level(up_level_unused), .pulse(up_pulse)
    );
    btn_conditioner #(.DEB_LEN(DEB_LEN)) u_btn_down (
        .clk(clk), .rst(rst), .raw(speed_down), .level(down_level_unused), .pulse(down_pulse)
    );

    mode_t          mode_q, mode_d;
    logic [SPW-1:0] speed;
    logic           countup;

    always_comb begin
        mode_d = mode_q;
        if (en_pulse) begin
            mode_d = (mode_q == MODE_RUN) ? MODE_PAUSE : MODE_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_PAUSE;
            speed   <= '0;
            countup <= 1'b1;
        end else begin
            mode_q <= mode_d;
            if (mode_q == MODE_RUN) begin
                countup <= ~dir_db;
            end
            if (up_pulse) begin
                if (speed != SPEED_MAX) speed <= speed + 1'b1;
            end else if (down_pulse && speed != '0) begin
                speed <= speed - 1'b1;
            end
        end
    end

    // Rate tick: rising edge of the prescaler bit chosen by the current speed
    logic [SLOW_EXP-1:0] presc;
    logic                tap, tap_q, tick;

    always_comb begin
        tap = 1'b0;
        for (int s = 0; s < NUM_SPEEDS; s++) begin
            if (speed == SPW'(s)) tap = presc[SLOW_EXP-1-s];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            tap_q <= 1'b0;
            tick  <= 1'b0;
        end else begin
            presc <= presc + 1'b1;
            tap_q <= tap;
            tick  <= tap && !tap_q;
        end
    end

    logic [CW-1:0]       count, count_inc, count_dec;
    logic [NUM_DIGITS:0] carry, borrow;
    logic                all_nines, is_zero;

    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_cell
        logic [3:0] d;
        assign d                   = count[4*i +: 4];
        assign carry[i+1]          = carry[i] && (d == 4'd9);
        assign borrow[i+1]         = borrow[i] && (d == 4'd0);
        assign count_inc[4*i +: 4] = !carry[i]  ? d : (d == 4'd9) ? 4'd0 : d + 4'd1;
        assign count_dec[4*i +: 4] = !borrow[i] ? d : (d == 4'd0) ? 4'd9 : d - 4'd1;
    end

    assign all_nines = carry[NUM_DIGITS];
    assign is_zero   = borrow[NUM_DIGITS];

    // The tick is judged against the pre-toggle mode, so a coincident en pulse does not veto it
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            max   <= 1'b0;
            min   <= 1'b0;
        end else if (tick && mode_q == MODE_RUN) begin
            if (countup) begin
                max <= all_nines;
                min <= 1'b0;
                if (!all_nines || WRAP_EN) count <= count_inc;
            end else begin
                min <= is_zero;
                max <= 1'b0;
                if (!is_zero || WRAP_EN) count <= count_dec;
            end
        end
    end

    logic [SCAN_EXP-1:0] scan_cnt;
    logic                scan_tick;
    logic [PW-1:0]       pos, pos_next;
    logic [4:0]          value_q, value_d;

    assign scan_tick = &scan_cnt;
    assign pos_next  = !scan_tick ? pos : (pos == POS_LAST) ? '0 : pos + 1'b1;

    // Value is chosen for the position DIGIT moves to, so the two always agree
    always_comb begin
        value_d = VAL_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pos_next == PW'(i)) value_d = {1'b0, count[4*i +: 4]};
        end
        if (pos_next == PW'(NUM_DIGITS)) value_d = countup ? VAL_ARROW_UP : VAL_ARROW_DN;
        if (pos_next == PW'(NUM_DIGITS + 1)) value_d = 5'(speed);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            pos      <= '0;
            DIGIT    <= ~(NPOS'(1));
            value_q  <= 5'd0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            pos      <= pos_next;
            value_q  <= value_d;
            if (scan_tick) DIGIT <= {DIGIT[NPOS-2:0], DIGIT[NPOS-1]};
        end
    end

    assign DISPLAY = seg_decode(value_q);

endmodule
